// File: rtl/ksort_controller.sv
// Job sequencer for the parallel k-sorting comparator array.
// Loads a (name,value) stream into the array, then reads back the min(k,count) smallest entries.
module ksort_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_K      = 1024,
  parameter int SETTLE     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           k,
  output logic                  busy,
  output logic                  err_k,
  output logic                  job_done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [31:0]           in_name,
  input  logic [DATA_WIDTH-1:0] in_value,
  output logic                  sort_reset,
  output logic                  sort_valid,
  output logic                  sort_done,
  output logic [31:0]           sort_k,
  output logic [31:0]           sort_name,
  output logic [DATA_WIDTH-1:0] sort_value,
  output logic                  sort_shift,
  input  logic [31:0]           res_name,
  input  logic [DATA_WIDTH-1:0] res_value,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [31:0]           out_name,
  output logic [DATA_WIDTH-1:0] out_value,
  output logic [31:0]           count
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, DRAIN, OUTPUT, GAP} state_t;

  state_t                  state, state_nxt;
  logic [SW-1:0]           settle_cnt;
  logic [31:0]             remaining;
  logic [31:0]             k_q;
  logic [31:0]             count_q;
  logic                    err_q;
  logic                    done_q;
  logic                    vld_p1;
  logic [31:0]             name_p1;
  logic [DATA_WIDTH-1:0]   value_p1;
  logic                    k_ok;
  logic                    in_hs;
  logic                    out_hs;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

  assign k_ok   = (k != 32'd0) && (k <= 32'(MAX_K));
  assign in_hs  = in_valid && (state == LOAD);
  assign out_hs = out_ready && (state == OUTPUT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = (state != IDLE);
    in_ready   = 1'b0;
    sort_reset = 1'b0;
    sort_done  = 1'b0;
    sort_shift = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    case (state)
      IDLE:   if (start && k_ok) state_nxt = CLEAR;
      CLEAR: begin
        sort_reset = 1'b1;
        state_nxt  = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        sort_done = 1'b1;
        if (settle_cnt == SW'(SETTLE - 1)) state_nxt = OUTPUT;
      end
      OUTPUT: begin
        out_valid = 1'b1;
        out_last  = (remaining == 32'd1);
        if (out_ready) begin
          sort_shift = 1'b1;
          state_nxt  = (remaining == 32'd1) ? IDLE : GAP;
        end
      end
      GAP:     state_nxt = OUTPUT;
      default: state_nxt = IDLE;
    endcase
  end

  // p0 -> p1: captured input item becomes the array load strobe one cycle later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1     <= 1'b0;
      name_p1    <= '0;
      value_p1   <= '0;
      k_q        <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      settle_cnt <= '0;
      remaining  <= '0;
    end else begin
      vld_p1 <= in_hs;
      done_q <= 1'b0;
      if (state == IDLE && start) begin
        if (k_ok) begin
          k_q     <= k;
          count_q <= '0;
          err_q   <= 1'b0;
        end else begin
          err_q   <= 1'b1;
        end
      end
      if (in_hs) begin
        name_p1  <= in_name;
        value_p1 <= in_value;
        count_q  <= sat_inc(count_q);
      end
      settle_cnt <= (state == DRAIN) ? settle_cnt + SW'(1) : '0;
      // count is final once DRAIN is entered, so latching every DRAIN cycle is safe
      if (state == DRAIN) remaining <= min_u32(k_q, count_q);
      if (out_hs) begin
        remaining <= remaining - 32'd1;
        if (remaining == 32'd1) done_q <= 1'b1;
      end
    end
  end

  assign sort_valid = vld_p1;
  assign sort_name  = name_p1;
  assign sort_value = value_p1;
  assign sort_k     = k_q;
  assign count      = count_q;
  assign err_k      = err_q;
  assign job_done   = done_q;
  assign out_name   = out_valid ? res_name  : '0;
  assign out_value  = out_valid ? res_value : '0;

endmodule

// File: tb/tb_ksort_controller.sv
// Directed bench for ksort_controller with a behavioural sorter-array model feeding res_*.
module tb_ksort_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] k = '0;
  logic        busy, err_k, job_done;
  logic        in_valid = 1'b0, in_last = 1'b0;
  logic        in_ready;
  logic [31:0] in_name = '0, in_value = '0;
  logic        sort_reset, sort_valid, sort_done, sort_shift;
  logic [31:0] sort_k, sort_name, sort_value;
  logic [31:0] res_name = '0, res_value = '0;
  logic        out_valid, out_last;
  logic        out_ready = 1'b0;
  logic [31:0] out_name, out_value, count;

  int vectors = 0;
  int errors  = 0;
  int n_sv = 0, n_done = 0, n_clr = 0;
  int got_v[$], got_n[$];
  bit got_l[$];
  int mq_v[$], mq_n[$];
  int stim[$];
  int pos;

  always #5 clk = ~clk;

  ksort_controller #(.DATA_WIDTH(32), .MAX_K(1024), .SETTLE(2)) dut (
    .clk(clk), .reset(rst_n), .start(start), .k(k), .busy(busy), .err_k(err_k),
    .job_done(job_done), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_name(in_name), .in_value(in_value), .sort_reset(sort_reset), .sort_valid(sort_valid),
    .sort_done(sort_done), .sort_k(sort_k), .sort_name(sort_name), .sort_value(sort_value),
    .sort_shift(sort_shift), .res_name(res_name), .res_value(res_value), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .out_name(out_name), .out_value(out_value),
    .count(count)
  );

  // Sorter array model: ascending list, head drives res_*
  always @(posedge clk) begin
    if (sort_reset) begin
      mq_v.delete();
      mq_n.delete();
    end else begin
      if (sort_shift && mq_v.size() > 0) begin
        void'(mq_v.pop_front());
        void'(mq_n.pop_front());
      end
      if (sort_valid) begin
        pos = mq_v.size();
        for (int i = mq_v.size() - 1; i >= 0; i--)
          if (mq_v[i] > int'(sort_value)) pos = i;
        mq_v.insert(pos, int'(sort_value));
        mq_n.insert(pos, int'(sort_name));
      end
    end
    res_value <= (mq_v.size() > 0) ? mq_v[0] : 0;
    res_name  <= (mq_n.size() > 0) ? mq_n[0] : 0;
  end

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      got_v.push_back(int'(out_value));
      got_n.push_back(int'(out_name));
      got_l.push_back(out_last);
    end
    if (sort_valid) n_sv++;
    if (job_done)   n_done++;
    if (sort_reset) n_clr++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [31:0] kk);
    start = 1'b1;
    k     = kk;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input bit gaps, input bit mark_last, output bit ok);
    bit acc;
    int g;
    ok = 1'b1;
    foreach (stim[i]) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        repeat (g) tick();
      end
      in_valid = 1'b1;
      in_value = stim[i];
      in_name  = stim[i] + 100;
      in_last  = mark_last && (i == stim.size() - 1);
      acc = 1'b0;
      for (int c = 0; c < 100 && !acc; c++) begin
        @(negedge clk);
        acc = in_ready;
        tick();
      end
      if (!acc) ok = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic wait_results(input int n_total, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk);
      #1;
      if (got_v.size() >= n_total) ok = 1'b1;
    end
    tick();
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk);
      #1;
      if (!busy) ok = 1'b1;
    end
    tick();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if ({busy, in_ready, sort_reset, sort_valid, sort_done, sort_shift, out_valid, out_last, job_done, err_k} !== 10'd0) begin errors++; $display("FAIL reset_ctrl: got %b required 0", {busy, in_ready, sort_reset, sort_valid, sort_done, sort_shift, out_valid, out_last, job_done, err_k}); end
    vectors++; if (sort_k !== 32'd0 || count !== 32'd0) begin errors++; $display("FAIL reset_k_count: got sort_k=%0d count=%0d required 0/0", sort_k, count); end
    vectors++; if ({sort_name, sort_value, out_name, out_value} !== 128'd0) begin errors++; $display("FAIL reset_data: got nonzero required 0"); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int b, sv0, d0;
    bit ok;
    b = got_v.size(); sv0 = n_sv; d0 = n_done;
    start_job(32'd3);
    vectors++; if (sort_reset !== 1'b1 || sort_k !== 32'd3) begin errors++; $display("FAIL basic_clear: got sort_reset=%0b sort_k=%0d required 1/3", sort_reset, sort_k); end
    stim = '{9, 4, 7, 1, 5};
    feed(1'b0, 1'b1, ok);
    vectors++; if (!ok) begin errors++; $display("FAIL basic_feed: got timeout required accept"); end
    out_ready = 1'b1;
    wait_idle(ok);
    out_ready = 1'b0;
    vectors++; if (!ok) begin errors++; $display("FAIL basic_idle: got timeout required idle"); end
    vectors++; if (n_sv - sv0 !== 5 || count !== 32'd5) begin errors++; $display("FAIL basic_load: got sort_valid=%0d count=%0d required 5/5", n_sv - sv0, count); end
    vectors++; if (got_v.size() - b !== 3) begin errors++; $display("FAIL basic_nres: got %0d required 3", got_v.size() - b); end
    else begin
      vectors++; if (got_v[b] !== 1 || got_v[b+1] !== 4 || got_v[b+2] !== 5) begin errors++; $display("FAIL basic_vals: got %0d,%0d,%0d required 1,4,5", got_v[b], got_v[b+1], got_v[b+2]); end
      vectors++; if (got_n[b+2] !== 105) begin errors++; $display("FAIL basic_name: got %0d required 105", got_n[b+2]); end
      vectors++; if ({got_l[b], got_l[b+1], got_l[b+2]} !== 3'b001) begin errors++; $display("FAIL basic_last: got %b required 001", {got_l[b], got_l[b+1], got_l[b+2]}); end
    end
    vectors++; if (n_done - d0 !== 1) begin errors++; $display("FAIL basic_done: got %0d pulses required 1", n_done - d0); end
  endtask

  task automatic test_k_gt_count();
    int b, d0;
    bit ok;
    b = got_v.size(); d0 = n_done;
    start_job(32'd8);
    stim = '{30, 10, 20};
    feed(1'b0, 1'b1, ok);
    out_ready = 1'b1;
    wait_idle(ok);
    out_ready = 1'b0;
    vectors++; if (!ok || busy !== 1'b0) begin errors++; $display("FAIL kbig_idle: got busy=%0b required 0", busy); end
    vectors++; if (got_v.size() - b !== 3) begin errors++; $display("FAIL kbig_nres: got %0d required 3", got_v.size() - b); end
    else begin
      vectors++; if (got_v[b] !== 10 || got_v[b+1] !== 20 || got_v[b+2] !== 30) begin errors++; $display("FAIL kbig_vals: got %0d,%0d,%0d required 10,20,30", got_v[b], got_v[b+1], got_v[b+2]); end
      vectors++; if ({got_l[b], got_l[b+1], got_l[b+2]} !== 3'b001) begin errors++; $display("FAIL kbig_last: got %b required 001", {got_l[b], got_l[b+1], got_l[b+2]}); end
    end
    vectors++; if (n_done - d0 !== 1) begin errors++; $display("FAIL kbig_done: got %0d required 1", n_done - d0); end
  endtask

  task automatic test_err_k();
    int b;
    bit ok;
    start_job(32'd0);
    vectors++; if (err_k !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL errk_zero: got err_k=%0b busy=%0b required 1/0", err_k, busy); end
    tick();
    start_job(32'd1025);
    vectors++; if (err_k !== 1'b1 || busy !== 1'b0 || sort_k !== 32'd8) begin errors++; $display("FAIL errk_big: got err_k=%0b busy=%0b sort_k=%0d required 1/0/8", err_k, busy, sort_k); end
    start_job(32'd1024);
    vectors++; if (err_k !== 1'b0 || sort_reset !== 1'b1 || sort_k !== 32'd1024) begin errors++; $display("FAIL errk_max: got err_k=%0b sort_reset=%0b sort_k=%0d required 0/1/1024", err_k, sort_reset, sort_k); end
    b = got_v.size();
    stim = '{8, 3};
    feed(1'b0, 1'b1, ok);
    out_ready = 1'b1;
    wait_idle(ok);
    out_ready = 1'b0;
    start_job(32'd0);
    vectors++; if (err_k !== 1'b1) begin errors++; $display("FAIL errk_again: got %0b required 1", err_k); end
    start_job(32'd2);
    vectors++; if (err_k !== 1'b0 || sort_reset !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL errk_clear: got err_k=%0b sort_reset=%0b busy=%0b required 0/1/1", err_k, sort_reset, busy); end
    stim = '{6, 2};
    feed(1'b0, 1'b1, ok);
    out_ready = 1'b1;
    wait_idle(ok);
    out_ready = 1'b0;
    vectors++; if (got_v.size() - b !== 4) begin errors++; $display("FAIL errk_nres: got %0d required 4", got_v.size() - b); end
    else begin
      vectors++; if (got_v[b] !== 3 || got_v[b+1] !== 8 || got_v[b+2] !== 2 || got_v[b+3] !== 6) begin errors++; $display("FAIL errk_vals: got %0d,%0d,%0d,%0d required 3,8,2,6", got_v[b], got_v[b+1], got_v[b+2], got_v[b+3]); end
    end
  endtask

  task automatic test_back_to_back();
    int b, sv0, held;
    bit ok;
    b = got_v.size(); sv0 = n_sv; held = 0;
    start_job(32'd4);
    stim = '{50, 20, 60, 10, 40, 30};
    feed(1'b1, 1'b1, ok);
    vectors++; if (!ok) begin errors++; $display("FAIL bp_feed: got timeout required accept"); end
    out_ready = 1'b1;
    wait_results(b + 2, ok);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin
        held++;
        vectors++; if (out_value !== 32'd30 || out_name !== 32'd130) begin errors++; $display("FAIL bp_hold: got %0d/%0d required 30/130", out_value, out_name); end
      end
    end
    vectors++; if (held !== 9 || got_v.size() - b !== 2) begin errors++; $display("FAIL bp_stall: got held=%0d nres=%0d required 9/2", held, got_v.size() - b); end
    tick();
    out_ready = 1'b1;
    wait_idle(ok);
    out_ready = 1'b0;
    vectors++; if (n_sv - sv0 !== 6 || count !== 32'd6) begin errors++; $display("FAIL bp_load: got sort_valid=%0d count=%0d required 6/6", n_sv - sv0, count); end
    vectors++; if (got_v.size() - b !== 4) begin errors++; $display("FAIL bp_nres: got %0d required 4", got_v.size() - b); end
    else begin
      vectors++; if (got_v[b] !== 10 || got_v[b+1] !== 20 || got_v[b+2] !== 30 || got_v[b+3] !== 40) begin errors++; $display("FAIL bp_vals: got %0d,%0d,%0d,%0d required 10,20,30,40", got_v[b], got_v[b+1], got_v[b+2], got_v[b+3]); end
      vectors++; if ({got_l[b], got_l[b+1], got_l[b+2], got_l[b+3]} !== 4'b0001) begin errors++; $display("FAIL bp_last: got %b required 0001", {got_l[b], got_l[b+1], got_l[b+2], got_l[b+3]}); end
    end
  endtask

  task automatic test_reset_midjob();
    int b, c0, d0;
    bit ok;
    d0 = n_done;
    start_job(32'd5);
    stim = '{11, 22};
    feed(1'b0, 1'b0, ok);
    vectors++; if (sort_valid !== 1'b1 || count !== 32'd2) begin errors++; $display("FAIL mid_load: got sort_valid=%0b count=%0d required 1/2", sort_valid, count); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if ({busy, in_ready, sort_valid, out_valid, job_done, sort_reset} !== 6'd0 || sort_k !== 32'd0 || count !== 32'd0) begin errors++; $display("FAIL mid_reset: got busy=%0b in_ready=%0b sort_valid=%0b sort_k=%0d count=%0d required all 0", busy, in_ready, sort_valid, sort_k, count); end
    vectors++; if (sort_name !== 32'd0 || sort_value !== 32'd0) begin errors++; $display("FAIL mid_data: got %0d/%0d required 0/0", sort_name, sort_value); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    vectors++; if (n_done !== d0 || busy !== 1'b0) begin errors++; $display("FAIL mid_nodone: got done=%0d busy=%0b required %0d/0", n_done, busy, d0); end
    b = got_v.size(); c0 = n_clr;
    start_job(32'd2);
    stim = '{77, 66};
    feed(1'b0, 1'b1, ok);
    out_ready = 1'b1;
    wait_idle(ok);
    out_ready = 1'b0;
    vectors++; if (n_clr - c0 !== 1) begin errors++; $display("FAIL mid_clear: got %0d required 1", n_clr - c0); end
    vectors++; if (got_v.size() - b !== 2) begin errors++; $display("FAIL mid_nres: got %0d required 2", got_v.size() - b); end
    else begin
      vectors++; if (got_v[b] !== 66 || got_v[b+1] !== 77) begin errors++; $display("FAIL mid_vals: got %0d,%0d required 66,77", got_v[b], got_v[b+1]); end
    end
  endtask

  task automatic test_start_in_output();
    int b;
    bit ok, seen;
    b = got_v.size(); seen = 1'b0;
    start_job(32'd2);
    stim = '{5, 2};
    feed(1'b0, 1'b1, ok);
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = out_valid;
    end
    tick();
    vectors++; if (!seen) begin errors++; $display("FAIL sio_wait: got no out_valid required out_valid"); end
    start = 1'b1;
    k     = 32'd7;
    tick();
    start = 1'b0;
    vectors++; if (sort_k !== 32'd2 || busy !== 1'b1 || out_valid !== 1'b1 || sort_reset !== 1'b0) begin errors++; $display("FAIL sio_ignore: got sort_k=%0d busy=%0b out_valid=%0b required 2/1/1", sort_k, busy, out_valid); end
    out_ready = 1'b1;
    wait_idle(ok);
    out_ready = 1'b0;
    repeat (3) tick();
    vectors++; if (busy !== 1'b0 || sort_k !== 32'd2) begin errors++; $display("FAIL sio_after: got busy=%0b sort_k=%0d required 0/2", busy, sort_k); end
    vectors++; if (got_v.size() - b !== 2) begin errors++; $display("FAIL sio_nres: got %0d required 2", got_v.size() - b); end
    else begin
      vectors++; if (got_v[b] !== 2 || got_v[b+1] !== 5) begin errors++; $display("FAIL sio_vals: got %0d,%0d required 2,5", got_v[b], got_v[b+1]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_k_gt_count();
    test_err_k();
    test_back_to_back();
    test_reset_midjob();
    test_start_in_output();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
